tile_line_fetcher: RTL and testbench

- Reads the tile map RAM and the tile pattern RAM for one scanline and writes one 8-pixel pattern byte per tile column into the line buffer.
- Acts as the read-side initiator for the two single-port synchronous RAMs in TileGraphics: address is presented, data arrives one clock later.
- The scanline renderer triggers it once per line during horizontal blank.

---
 rtl/tile_line_fetcher_pkg.sv | 30 +++
 rtl/tile_line_fetcher_if.sv | 33 +++
 rtl/tile_line_fetcher_addr_gen.sv | 47 ++++
 rtl/tile_line_fetcher.sv | 163 ++++++++++++++++
 tb/tb_tile_line_fetcher.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_line_fetcher_pkg.sv
// ---------------------------------------------------------------------------
// tile_defs
//   Shared constants and types for the tile graphics fetch path.
//   - TILES_X / LINES     : line geometry (32 tile columns, 240 visible lines)
//   - MAP_A / PAT_A / D   : RAM address and data widths
//   - ROW_OFS / FY_W      : address packing, map = {row, col}, pattern = {tile, fine_y}
//   - fetch_state_t       : line fetcher FSM encoding
// ---------------------------------------------------------------------------
package tile_defs;

  localparam int TILES_X = 32;
  localparam int LINES   = 240;
  localparam int MAP_A   = 10;
  localparam int PAT_A   = 11;
  localparam int D       = 8;

  // Map address: row field starts at bit ROW_OFS, column below it.
  // Pattern address: fine_y occupies the low FY_W bits.
  localparam int ROW_OFS = 5;
  localparam int FY_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAP_A = 3'd1,
    ST_MAP_D = 3'd2,
    ST_PAT_A = 3'd3,
    ST_PAT_D = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/tile_line_fetcher_if.sv
// ---------------------------------------------------------------------------
// tile_line_fetcher_if
//   Bundles the fetcher's control handshake, the two RAM read ports and the
//   line-buffer write port.
//   modport master : the fetcher (drives busy/done, RAM addresses, line buffer)
//   modport slave  : renderer + RAMs + line buffer (drive start/line/RAM data)
// ---------------------------------------------------------------------------
interface tile_line_fetcher_if;
  import tile_defs::*;

  logic             start;
  logic [7:0]       line;
  logic             busy;
  logic             done;
  logic [MAP_A-1:0] map_addr;
  logic [D-1:0]     map_dout;
  logic [PAT_A-1:0] pat_addr;
  logic [D-1:0]     pat_dout;
  logic             lb_we;
  logic [4:0]       lb_addr;
  logic [D-1:0]     lb_data;

  modport master (
    input  start, line, map_dout, pat_dout,
    output busy, done, map_addr, pat_addr, lb_we, lb_addr, lb_data
  );

  modport slave (
    output start, line, map_dout, pat_dout,
    input  busy, done, map_addr, pat_addr, lb_we, lb_addr, lb_data
  );

endinterface

// File: rtl/tile_line_fetcher_addr_gen.sv
// ---------------------------------------------------------------------------
// tile_addr_gen
//   Combinational address generator for tile fetches; shared with a future
//   sprite fetcher.
//   line, scroll_y -> ey_new   : effective line, wrapped mod LINES
//   ey, k, scroll_tx -> map_addr : {ey[7:3], (k + scroll_tx) mod 32}
//   tile, ey -> pat_addr       : {tile, ey[2:0]}
// ---------------------------------------------------------------------------
module tile_addr_gen #(
  parameter int LINES = tile_defs::LINES,
  parameter int MAP_A = tile_defs::MAP_A,
  parameter int PAT_A = tile_defs::PAT_A,
  parameter int D     = tile_defs::D
) (
  input  logic [7:0]       line,
  input  logic [7:0]       scroll_y,
  output logic [7:0]       ey_new,
  input  logic [7:0]       ey,
  input  logic [4:0]       k,
  input  logic [4:0]       scroll_tx,
  input  logic [D-1:0]     tile,
  output logic [MAP_A-1:0] map_addr,
  output logic [PAT_A-1:0] pat_addr
);
  import tile_defs::*;

  logic [8:0] y_sum;
  logic [4:0] col;

  always_comb begin
    // Both operands are below LINES, so one conditional subtract is a full wrap.
    y_sum  = {1'b0, line} + {1'b0, scroll_y};
    ey_new = (y_sum >= 9'(LINES)) ? 8'(y_sum - 9'(LINES)) : y_sum[7:0];

    // 5-bit add wraps horizontally for free.
    col = k + scroll_tx;

    map_addr                      = '0;
    map_addr[MAP_A-1:ROW_OFS]     = ey[7:FY_W];
    map_addr[ROW_OFS-1:0]         = col;

    pat_addr                      = '0;
    pat_addr[PAT_A-1:FY_W]        = tile;
    pat_addr[FY_W-1:0]            = ey[FY_W-1:0];
  end

endmodule

// File: rtl/tile_line_fetcher.sv
// ---------------------------------------------------------------------------
// tile_line_fetcher
//   Fetches one scanline of tile patterns: for each tile column k = 0..31 it
//   reads the map RAM (tile index) and then the pattern RAM (row byte) and
//   writes the byte to line-buffer column k. Each RAM read takes two cycles,
//   so a tile takes four and a line finishes with its last write in cycle 128
//   after the accepting edge, followed by a one-cycle done pulse.
//
//   Ports
//     clk, rst_n  : clock, asynchronous active-low reset
//     bus         : tile_line_fetcher_if.master
//                   start/line in, busy/done out, map/pat RAM read ports,
//                   line-buffer write port (lb_we, lb_addr, lb_data)
//     scroll_y, scroll_tx : only when SCROLL_EN is defined; sampled with start
//
//   Build option
//     SCROLL_EN : adds vertical (mod LINES) and horizontal (mod 32) scrolling
//                 of the RAM addressing; lb_addr is never scrolled.
// ---------------------------------------------------------------------------
module tile_line_fetcher #(
  parameter int TILES_X = tile_defs::TILES_X,
  parameter int LINES   = tile_defs::LINES,
  parameter int MAP_A   = tile_defs::MAP_A,
  parameter int PAT_A   = tile_defs::PAT_A,
  parameter int D       = tile_defs::D
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SCROLL_EN
  input  logic [7:0] scroll_y,
  input  logic [4:0] scroll_tx,
`endif
  tile_line_fetcher_if.master bus
);
  import tile_defs::*;

  fetch_state_t     state_reg;
  logic [4:0]       k_reg;
  logic [7:0]       ey_reg;
  logic [4:0]       tx_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             lb_we_reg;
  logic [4:0]       lb_addr_reg;
  logic [D-1:0]     lb_data_reg;
  logic [MAP_A-1:0] map_addr_reg;
  logic [PAT_A-1:0] pat_addr_reg;

  logic [7:0] sy_in;
  logic [4:0] tx_in;

`ifdef SCROLL_EN
  assign sy_in = scroll_y;
  assign tx_in = scroll_tx;
`else
  assign sy_in = '0;
  assign tx_in = '0;
`endif

  // The address generator serves two moments: the accepting edge (fresh
  // line/scroll inputs, k = 0) and the end of each tile (latched ey/scroll,
  // k + 1), so its inputs are muxed on idle.
  logic             idle;
  logic [7:0]       ey_new;
  logic [7:0]       ey_sel;
  logic [4:0]       k_sel;
  logic [4:0]       tx_sel;
  logic [MAP_A-1:0] map_addr_next;
  logic [PAT_A-1:0] pat_addr_next;
  logic             start_ok;

  assign idle   = (state_reg == ST_IDLE);
  assign ey_sel = idle ? ey_new : ey_reg;
  assign k_sel  = idle ? 5'd0 : k_reg + 5'd1;
  assign tx_sel = idle ? tx_in : tx_reg;

  // busy_reg is still high in the cycle of the last write and done_reg marks
  // the done cycle; starts in either are dropped.
  assign start_ok = idle && !busy_reg && !done_reg && bus.start &&
                    (bus.line < 8'(LINES));

  tile_addr_gen #(
    .LINES (LINES),
    .MAP_A (MAP_A),
    .PAT_A (PAT_A),
    .D     (D)
  ) u_addr_gen (
    .line      (bus.line),
    .scroll_y  (sy_in),
    .ey_new    (ey_new),
    .ey        (ey_sel),
    .k         (k_sel),
    .scroll_tx (tx_sel),
    .tile      (bus.map_dout),
    .map_addr  (map_addr_next),
    .pat_addr  (pat_addr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      k_reg        <= '0;
      ey_reg       <= '0;
      tx_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      lb_we_reg    <= 1'b0;
      lb_addr_reg  <= '0;
      lb_data_reg  <= '0;
      map_addr_reg <= '0;
      pat_addr_reg <= '0;
    end else begin
      lb_we_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (busy_reg) begin
            // Cycle after the last write: close out the line.
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            k_reg    <= '0;
          end else if (start_ok) begin
            ey_reg       <= ey_new;
            tx_reg       <= tx_in;
            k_reg        <= '0;
            busy_reg     <= 1'b1;
            map_addr_reg <= map_addr_next;
            state_reg    <= ST_MAP_A;
          end
        end
        ST_MAP_A: state_reg <= ST_MAP_D;
        ST_MAP_D: begin
          pat_addr_reg <= pat_addr_next;
          state_reg    <= ST_PAT_A;
        end
        ST_PAT_A: state_reg <= ST_PAT_D;
        ST_PAT_D: begin
          lb_we_reg   <= 1'b1;
          lb_addr_reg <= k_reg;
          lb_data_reg <= bus.pat_dout;
          if (k_reg == 5'(TILES_X - 1)) begin
            state_reg <= ST_IDLE;
          end else begin
            // Next tile's map address goes out on the same edge as this write.
            k_reg        <= k_reg + 5'd1;
            map_addr_reg <= map_addr_next;
            state_reg    <= ST_MAP_A;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.lb_we    = lb_we_reg;
  assign bus.lb_addr  = lb_addr_reg;
  assign bus.lb_data  = lb_data_reg;
  assign bus.map_addr = map_addr_reg;
  assign bus.pat_addr = pat_addr_reg;

endmodule

// File: tb/tb_tile_line_fetcher.sv
`timescale 1ns/1ps
module tb_tile_line_fetcher;

  localparam int NC_MAX = 140;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_line_fetcher_if bus ();

`ifdef SCROLL_EN
  logic [7:0] scroll_y = '0;
  logic [4:0] scroll_tx = '0;
`endif

  tile_line_fetcher dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SCROLL_EN
    .scroll_y  (scroll_y),
    .scroll_tx (scroll_tx),
`endif
    .bus       (bus)
  );

  // Single-port synchronous RAM models: data one cycle after the address.
  logic [7:0] map_mem [0:1023];
  logic [7:0] pat_mem [0:2047];
  always @(posedge clk) begin
    bus.map_dout <= map_mem[bus.map_addr];
    bus.pat_dout <= pat_mem[bus.pat_addr];
  end

  // Recorded and expected per-cycle outputs of one fetch.
  logic       r_busy [NC_MAX], r_done [NC_MAX], r_we [NC_MAX];
  logic [4:0] r_lba  [NC_MAX];
  logic [7:0] r_lbd  [NC_MAX];
  logic [9:0] r_map  [NC_MAX];
  logic [10:0] r_pat [NC_MAX];
  logic       e_busy [NC_MAX], e_done [NC_MAX], e_we [NC_MAX];
  logic [4:0] e_lba  [NC_MAX];
  logic [7:0] e_lbd  [NC_MAX];
  logic [9:0] e_map  [NC_MAX];
  logic [10:0] e_pat [NC_MAX];

  // Model of the held output registers.
  logic [9:0]  m_map;
  logic [10:0] m_pat;
  logic [4:0]  m_lba;
  logic [7:0]  m_lbd;
  int m_sy, m_tx;
  int last_writes;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int l, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s line=%0d cycle=%0d actual=0x%0h required=0x%0h",
                  name, l, c, act, exp);
  endtask

  function automatic logic [31:0] act_of(input int cat, input int c);
    case (cat)
      0: return 32'(r_busy[c]);
      1: return 32'(r_done[c]);
      2: return 32'(r_we[c]);
      3: return 32'(r_lba[c]);
      4: return 32'(r_lbd[c]);
      5: return 32'(r_map[c]);
      default: return 32'(r_pat[c]);
    endcase
  endfunction

  function automatic logic [31:0] exp_of(input int cat, input int c);
    case (cat)
      0: return 32'(e_busy[c]);
      1: return 32'(e_done[c]);
      2: return 32'(e_we[c]);
      3: return 32'(e_lba[c]);
      4: return 32'(e_lbd[c]);
      5: return 32'(e_map[c]);
      default: return 32'(e_pat[c]);
    endcase
  endfunction

  function automatic string cat_name(input int cat);
    case (cat)
      0: return "busy";
      1: return "done";
      2: return "lb_we";
      3: return "lb_addr";
      4: return "lb_data";
      5: return "map_addr";
      default: return "pat_addr";
    endcase
  endfunction

  // Starts a fetch at the current negedge, records cycles 0..nc-1 (sampled at
  // negedge), optionally pulses a second start in cycle xc, then compares
  // against a model built from the timing rules and the bench's own RAMs.
  task automatic fetch(input int l, input bit acc, input int nc, input int xc, input int xl);
    logic [7:0] eyv;
    logic [7:0] tile;
    int k, bad, nw;
    bus.start = 1'b1;
    bus.line  = 8'(l);
    @(posedge clk);
    for (int c = 0; c < nc; c++) begin
      @(negedge clk);
      r_busy[c] = bus.busy;
      r_done[c] = bus.done;
      r_we[c]   = bus.lb_we;
      r_lba[c]  = bus.lb_addr;
      r_lbd[c]  = bus.lb_data;
      r_map[c]  = bus.map_addr;
      r_pat[c]  = bus.pat_addr;
      bus.start = (c == xc);
      if (c == xc) bus.line = 8'(xl);
    end
    bus.start = 1'b0;

    eyv = 8'((l + m_sy) % 240);
    nw = 0;
    for (int c = 0; c < nc; c++) begin
      if (acc) begin
        if (c % 4 == 0 && c >= 4 && c <= 128) begin
          m_lba = 5'(c / 4 - 1);
          m_lbd = pat_mem[m_pat];
        end
        if (c % 4 == 0 && c <= 124) begin
          k = c / 4;
          m_map = {eyv[7:3], 5'((k + m_tx) % 32)};
        end
        if (c % 4 == 2 && c <= 126) begin
          tile = map_mem[m_map];
          m_pat = {tile, eyv[2:0]};
        end
      end
      e_busy[c] = acc && (c <= 128);
      e_done[c] = acc && (c == 129);
      e_we[c]   = acc && (c % 4 == 0) && (c >= 4) && (c <= 128);
      e_lba[c]  = m_lba;
      e_lbd[c]  = m_lbd;
      e_map[c]  = m_map;
      e_pat[c]  = m_pat;
      if (r_we[c] === 1'b1) nw++;
    end
    last_writes = nw;

    for (int cat = 0; cat < 7; cat++) begin
      bad = -1;
      for (int c = 0; c < nc; c++)
        if (bad < 0 && act_of(cat, c) !== exp_of(cat, c)) bad = c;
      if (bad < 0) bad = 0;
      chk(cat_name(cat), l, bad, act_of(cat, bad), exp_of(cat, bad));
    end
    $display("fetch line=%0d accepted=%0d writes=%0d", l, acc, nw);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     -1, 0, 32'(bus.busy),     0);
    chk({tag, "_done"},     -1, 0, 32'(bus.done),     0);
    chk({tag, "_lb_we"},    -1, 0, 32'(bus.lb_we),    0);
    chk({tag, "_lb_addr"},  -1, 0, 32'(bus.lb_addr),  0);
    chk({tag, "_lb_data"},  -1, 0, 32'(bus.lb_data),  0);
    chk({tag, "_map_addr"}, -1, 0, 32'(bus.map_addr), 0);
    chk({tag, "_pat_addr"}, -1, 0, 32'(bus.pat_addr), 0);
  endtask

  typedef struct {
    int         line;
    bit         acc;
    logic [9:0] map0;    // map_addr in cycle 0
    logic [7:0] d4;      // lb_data in cycle 4
    int         writes;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [10:0] a;
    // Map fill {row[2:0], col}, pattern fill tile ^ fine_y.
    vecs[0] = '{line: 0,   acc: 1'b1, map0: 10'h000, d4: 8'h00, writes: 32};
    vecs[1] = '{line: 7,   acc: 1'b1, map0: 10'h000, d4: 8'h07, writes: 32};
    vecs[2] = '{line: 8,   acc: 1'b1, map0: 10'h020, d4: 8'h20, writes: 32};
    vecs[3] = '{line: 100, acc: 1'b1, map0: 10'h180, d4: 8'h84, writes: 32};
    vecs[4] = '{line: 239, acc: 1'b1, map0: 10'h3A0, d4: 8'hA7, writes: 32};
    vecs[5] = '{line: 240, acc: 1'b0, map0: 10'h3BF, d4: 8'hB8, writes: 0};
    vecs[6] = '{line: 255, acc: 1'b0, map0: 10'h3BF, d4: 8'hB8, writes: 0};

    bus.start = 1'b0;
    bus.line  = '0;
    m_map = '0; m_pat = '0; m_lba = '0; m_lbd = '0;
    m_sy = 0; m_tx = 0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic fetch with a single marked tile
    for (int i = 0; i < 1024; i++) map_mem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) pat_mem[i] = 8'h00;
    map_mem[3*32+5]   = 8'h41;
    pat_mem[8'h41*8+2] = 8'hA5;
    fetch(26, 1'b1, 131, -1, 0);
    chk("basic_we24",   26, 24,  32'(r_we[24]),  1);
    chk("basic_addr24", 26, 24,  32'(r_lba[24]), 5);
    chk("basic_data24", 26, 24,  32'(r_lbd[24]), 32'hA5);
    chk("basic_writes", 26, -1,  last_writes,    32);
    chk("basic_busy128", 26, 128, 32'(r_busy[128]), 1);
    chk("basic_busy129", 26, 129, 32'(r_busy[129]), 0);
    chk("basic_done129", 26, 129, 32'(r_done[129]), 1);
    chk("basic_done130", 26, 130, 32'(r_done[130]), 0);

    // Start in cycle 130 accepted; start in cycle 40 ignored
    fetch(26, 1'b1, 140, 40, 100);
    chk("b2b_map0",   26, 0,  32'(r_map[0]), 32'h060);
    chk("busy_ign_writes", 26, -1, last_writes, 32);

    // Start in the done cycle ignored
    fetch(5, 1'b1, 140, 129, 7);
    chk("done_ign_busy135", 5, 135, 32'(r_busy[135]), 0);

    // Out-of-range line while idle
    fetch(240, 1'b0, 20, -1, 0);
    chk("oor_writes", 240, -1, last_writes, 0);

    // Table-driven vectors
    for (int i = 0; i < 1024; i++) begin
      a = 11'(i);
      map_mem[i] = {a[7:5], a[4:0]};
    end
    for (int i = 0; i < 2048; i++) begin
      a = 11'(i);
      pat_mem[i] = a[10:3] ^ {5'd0, a[2:0]};
    end
    for (int v = 0; v < 7; v++) begin
      fetch(vecs[v].line, vecs[v].acc, vecs[v].acc ? 131 : 20, -1, 0);
      chk("tbl_map0",   vecs[v].line, 0,  32'(r_map[0]), 32'(vecs[v].map0));
      chk("tbl_data4",  vecs[v].line, 4,  32'(r_lbd[4]), 32'(vecs[v].d4));
      chk("tbl_writes", vecs[v].line, -1, last_writes,   vecs[v].writes);
    end

    // Reset mid-line at cycle 50
    bus.start = 1'b1;
    bus.line  = 8'd50;
    @(posedge clk);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midreset_no_done", 50, c, 32'(bus.done), 0);
    end
    rst_n = 1'b1;
    m_map = '0; m_pat = '0; m_lba = '0; m_lbd = '0;
    $display("reset asserted mid-line at cycle 50");
    fetch(0, 1'b1, 131, -1, 0);
    chk("post_reset_writes", 0, -1, last_writes, 32);

`ifdef SCROLL_EN
    // Scrolled fetch: ey = (230 + 16) mod 240 = 6, first column 31
    scroll_y  = 8'd16;
    scroll_tx = 5'd31;
    m_sy = 16;
    m_tx = 31;
    fetch(230, 1'b1, 131, -1, 0);
    chk("scroll_map0",  230, 0, 32'(r_map[0]), 32'h01F);
    chk("scroll_map4",  230, 4, 32'(r_map[4]), 32'h000);
    chk("scroll_lba4",  230, 4, 32'(r_lba[4]), 0);
    scroll_y  = 8'd0;
    scroll_tx = 5'd0;
    m_sy = 0;
    m_tx = 0;
`endif

    // Full sweep: map holds its column, pattern bytes tile ^ fine_y
    for (int i = 0; i < 1024; i++) begin
      a = 11'(i);
      map_mem[i] = {3'd0, a[4:0]};
    end
    for (int l = 0; l < 240; l++)
      fetch(l, 1'b1, 131, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
